// File: rtl/div_pipelined_result_if.sv
// div_pipelined_result_if: handshake and data bus between the last divider latch, the result stage and the execute stage.
interface div_pipelined_result_if;
   logic        iPREVIOUS_VALID;
   logic        oPREVIOUS_BUSY;
   logic        iPREVIOUS_SIGN;
   logic [31:0] iPREVIOUS_DIVISOR;
   logic [31:0] iPREVIOUS_DIVIDEND;
   logic [31:0] iPREVIOUS_Q;
   logic [31:0] iPREVIOUS_R;
   logic        oNEXT_VALID;
   logic        iNEXT_BUSY;
   logic [31:0] oNEXT_QUOTIENT;
   logic [31:0] oNEXT_REMAINDER;
   logic [1:0]  oNEXT_EXCEPTION;
   modport master (
      output iPREVIOUS_VALID, iPREVIOUS_SIGN, iPREVIOUS_DIVISOR, iPREVIOUS_DIVIDEND, iPREVIOUS_Q, iPREVIOUS_R, iNEXT_BUSY,
      input  oPREVIOUS_BUSY, oNEXT_VALID, oNEXT_QUOTIENT, oNEXT_REMAINDER, oNEXT_EXCEPTION
   );
   modport slave (
      input  iPREVIOUS_VALID, iPREVIOUS_SIGN, iPREVIOUS_DIVISOR, iPREVIOUS_DIVIDEND, iPREVIOUS_Q, iPREVIOUS_R, iNEXT_BUSY,
      output oPREVIOUS_BUSY, oNEXT_VALID, oNEXT_QUOTIENT, oNEXT_REMAINDER, oNEXT_EXCEPTION
   );
endinterface

// File: rtl/div_pipelined_result.sv
// div_pipelined_result: sign correction, divide-by-zero override and result FIFO for the pipelined divider.
// Define DIV_PIPELINED_RESULT_EXCEPTION_EN to store and report {overflow, div_zero} per result.
module div_pipelined_result #(
   parameter int DEPTH   = 4,
   parameter int DEPTH_W = 2
) (
   input logic iCLOCK,
   input logic inRESET,
   input logic iREMOVE,
   div_pipelined_result_if.slave bus
);
   localparam logic [DEPTH_W:0] FULL = (DEPTH_W+1)'(DEPTH);
   logic [DEPTH_W-1:0] wrPtr, rdPtr;
   logic [DEPTH_W:0]   count;
   logic [31:0]        qMem [DEPTH];
   logic [31:0]        rMem [DEPTH];
   logic               push, pop, divZero, negQ, negR;
   logic [31:0]        resQ, resR;
   always_comb begin
      divZero = bus.iPREVIOUS_DIVISOR == 32'd0;
      negQ    = bus.iPREVIOUS_SIGN & (bus.iPREVIOUS_DIVIDEND[31] ^ bus.iPREVIOUS_DIVISOR[31]);
      negR    = bus.iPREVIOUS_SIGN & bus.iPREVIOUS_DIVIDEND[31];
      resQ    = divZero ? 32'hFFFF_FFFF : negQ ? -bus.iPREVIOUS_Q : bus.iPREVIOUS_Q;
      resR    = divZero ? bus.iPREVIOUS_DIVIDEND : negR ? -bus.iPREVIOUS_R : bus.iPREVIOUS_R;
      push    = bus.iPREVIOUS_VALID && !bus.oPREVIOUS_BUSY;
      pop     = bus.oNEXT_VALID && !bus.iNEXT_BUSY;
   end
   assign bus.oPREVIOUS_BUSY  = count == FULL;
   assign bus.oNEXT_VALID     = count != '0;
   assign bus.oNEXT_QUOTIENT  = qMem[rdPtr];
   assign bus.oNEXT_REMAINDER = rMem[rdPtr];
   // Flush wins over push and pop; storage contents are left stale behind the reset pointers.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            qMem[i] <= '0;
            rMem[i] <= '0;
         end
      end else if (iREMOVE) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            qMem[wrPtr] <= resQ;
            rMem[wrPtr] <= resR;
            wrPtr       <= wrPtr + DEPTH_W'(1);
         end
         if (pop) rdPtr <= rdPtr + DEPTH_W'(1);
         count <= count + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(pop);
      end
   end
`ifdef DIV_PIPELINED_RESULT_EXCEPTION_EN
   logic [1:0] excMem [DEPTH];
   logic       overflow;
   assign overflow = bus.iPREVIOUS_SIGN && bus.iPREVIOUS_DIVIDEND == 32'h8000_0000 && bus.iPREVIOUS_DIVISOR == 32'hFFFF_FFFF;
   assign bus.oNEXT_EXCEPTION = excMem[rdPtr];
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         for (int i = 0; i < DEPTH; i++) excMem[i] <= '0;
      end else if (!iREMOVE && push) begin
         excMem[wrPtr] <= {overflow, divZero};
      end
   end
`else
   assign bus.oNEXT_EXCEPTION = 2'b00;
`endif
endmodule

// File: tb/tb_div_pipelined_result.sv
// tb_div_pipelined_result: directed vector table plus back-pressure, streaming, flush and async-reset sequences.
module tb_div_pipelined_result;
   logic iCLOCK = 1'b0;
   logic inRESET = 1'b0;
   logic iREMOVE = 1'b0;
   int   errors = 0;
   int   checks = 0;
   div_pipelined_result_if bus ();
   div_pipelined_result #(.DEPTH(4), .DEPTH_W(2)) dut (
      .iCLOCK (iCLOCK),
      .inRESET(inRESET),
      .iREMOVE(iREMOVE),
      .bus    (bus.slave)
   );
   always #5 iCLOCK = ~iCLOCK;
`ifdef DIV_PIPELINED_RESULT_EXCEPTION_EN
   localparam logic EXC_EN = 1'b1;
`else
   localparam logic EXC_EN = 1'b0;
`endif
   typedef struct {
      string       name;
      logic        sign;
      logic [31:0] dividend, divisor, q, r, expQ, expR;
      logic [1:0]  expExc;
   } vec_t;
   vec_t vecs [9];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic s, input logic [31:0] dd, input logic [31:0] dv, input logic [31:0] q, input logic [31:0] r);
      bus.iPREVIOUS_VALID    = v;
      bus.iPREVIOUS_SIGN     = s;
      bus.iPREVIOUS_DIVIDEND = dd;
      bus.iPREVIOUS_DIVISOR  = dv;
      bus.iPREVIOUS_Q        = q;
      bus.iPREVIOUS_R        = r;
   endtask
   task automatic item(input int i);
      drive(1'b1, 1'b0, 32'd500 + 32'(i), 32'd1, 32'd100 + 32'(i), 32'(i));
   endtask
   initial begin
      vecs[0] = '{"neg7div2",   1'b1, 32'hFFFF_FFF9, 32'h2,         32'h3,         32'h1,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00};
      vecs[1] = '{"divzero",    1'b1, 32'h1234_5678, 32'h0,         32'hDEAD_BEEF, 32'h0,  32'hFFFF_FFFF, 32'h1234_5678, 2'b01};
      vecs[2] = '{"overflow",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,  32'h8000_0000, 32'h0,         2'b10};
      vecs[3] = '{"u100div7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,  32'd14,        32'd2,         2'b00};
      vecs[4] = '{"ubigdiv2",   1'b0, 32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC, 32'h1,  32'h7FFF_FFFC, 32'h1,         2'b00};
      vecs[5] = '{"7divneg2",   1'b1, 32'h7,         32'hFFFF_FFFE, 32'h3,         32'h1,  32'hFFFF_FFFD, 32'h1,         2'b00};
      vecs[6] = '{"neg7divneg2",1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h3,         32'h1,  32'h3,         32'hFFFF_FFFF, 2'b00};
      vecs[7] = '{"negdivzero", 1'b1, 32'h8000_0000, 32'h0,         32'h5,         32'h7,  32'hFFFF_FFFF, 32'h8000_0000, 2'b01};
      vecs[8] = '{"udivzero",   1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01};
      drive(1'b0, 1'b0, '0, '0, '0, '0);
      bus.iNEXT_BUSY = 1'b0;
      #12;
      chk("rst_valid", 32'(bus.oNEXT_VALID), 0);
      chk("rst_busy", 32'(bus.oPREVIOUS_BUSY), 0);
      chk("rst_q", bus.oNEXT_QUOTIENT, 0);
      chk("rst_r", bus.oNEXT_REMAINDER, 0);
      chk("rst_exc", 32'(bus.oNEXT_EXCEPTION), 0);
      @(negedge iCLOCK);
      inRESET = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge iCLOCK);
         drive(1'b1, vecs[i].sign, vecs[i].dividend, vecs[i].divisor, vecs[i].q, vecs[i].r);
         @(negedge iCLOCK);
         bus.iPREVIOUS_VALID = 1'b0;
         chk({vecs[i].name, "_valid"}, 32'(bus.oNEXT_VALID), 1);
         chk({vecs[i].name, "_q"}, bus.oNEXT_QUOTIENT, vecs[i].expQ);
         chk({vecs[i].name, "_r"}, bus.oNEXT_REMAINDER, vecs[i].expR);
         chk({vecs[i].name, "_exc"}, 32'(bus.oNEXT_EXCEPTION), EXC_EN ? 32'(vecs[i].expExc) : 0);
         @(negedge iCLOCK);
         chk({vecs[i].name, "_drained"}, 32'(bus.oNEXT_VALID), 0);
      end
      bus.iNEXT_BUSY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge iCLOCK);
         item(i);
         chk($sformatf("bp_busy%0d", i), 32'(bus.oPREVIOUS_BUSY), i == 4 ? 1 : 0);
      end
      chk("bp_head0", bus.oNEXT_QUOTIENT, 100);
      @(negedge iCLOCK);
      chk("bp_held_busy", 32'(bus.oPREVIOUS_BUSY), 1);
      bus.iNEXT_BUSY = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge iCLOCK);
         if (k == 1) chk("bp_busy_fall", 32'(bus.oPREVIOUS_BUSY), 0);
         if (k == 2) bus.iPREVIOUS_VALID = 1'b0;
         chk($sformatf("bp_valid%0d", k), 32'(bus.oNEXT_VALID), 1);
         chk($sformatf("bp_order%0d", k), bus.oNEXT_QUOTIENT, 100 + k);
      end
      @(negedge iCLOCK);
      chk("bp_empty", 32'(bus.oNEXT_VALID), 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge iCLOCK);
         item(10 + i);
         chk($sformatf("st_busy%0d", i), 32'(bus.oPREVIOUS_BUSY), 0);
         if (i > 0) chk($sformatf("st_q%0d", i), bus.oNEXT_QUOTIENT, 32'd109 + 32'(i));
         if (i > 0) chk($sformatf("st_r%0d", i), bus.oNEXT_REMAINDER, 32'd9 + 32'(i));
      end
      @(negedge iCLOCK);
      bus.iPREVIOUS_VALID = 1'b0;
      chk("st_last", bus.oNEXT_QUOTIENT, 129);
      @(negedge iCLOCK);
      chk("st_empty", 32'(bus.oNEXT_VALID), 0);
      bus.iNEXT_BUSY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge iCLOCK);
         item(40 + i);
      end
      @(negedge iCLOCK);
      item(43);
      iREMOVE = 1'b1;
      @(negedge iCLOCK);
      iREMOVE = 1'b0;
      bus.iPREVIOUS_VALID = 1'b0;
      chk("fl_valid", 32'(bus.oNEXT_VALID), 0);
      chk("fl_busy", 32'(bus.oPREVIOUS_BUSY), 0);
      bus.iNEXT_BUSY = 1'b0;
      repeat (3) @(negedge iCLOCK);
      chk("fl_stays_empty", 32'(bus.oNEXT_VALID), 0);
      item(50);
      @(negedge iCLOCK);
      bus.iPREVIOUS_VALID = 1'b0;
      chk("fl_next_q", bus.oNEXT_QUOTIENT, 150);
      bus.iNEXT_BUSY = 1'b1;
      item(60);
      @(negedge iCLOCK);
      bus.iPREVIOUS_VALID = 1'b0;
      chk("ar_before", 32'(bus.oNEXT_VALID), 1);
      #2 inRESET = 1'b0;
      #1;
      chk("ar_valid", 32'(bus.oNEXT_VALID), 0);
      chk("ar_q", bus.oNEXT_QUOTIENT, 0);
      @(negedge iCLOCK);
      inRESET = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
